// File: rtl/sprite_blit.sv
// sprite_blit: walks a sprite ROM in row-major order and copies each pixel
// into a framebuffer at a requested (x, y) position. Transparent pixels are
// skipped and pixels landing outside the framebuffer are clipped. The
// framebuffer can stall the walk at any pixel by dropping fb_ready.
module sprite_blit #(
    parameter  int WIDTH     = 4,
    parameter  int SPR_W     = 16,
    parameter  int SPR_H     = 16,
    parameter  int FB_W      = 160,
    parameter  int FB_H      = 120,
    parameter  int CORDW     = 16,
    parameter  int TRANSP    = 0,
    localparam int SPR_ADDRW = $clog2(SPR_W*SPR_H),
    localparam int FB_ADDRW  = $clog2(FB_W*FB_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CORDW-1:0]     x,
    input  logic [CORDW-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [SPR_ADDRW-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    input  logic                 fb_ready,
    output logic                 fb_we,
    output logic [FB_ADDRW-1:0]  fb_addr,
    output logic [WIDTH-1:0]     fb_data
);

    // Counter widths are kept at least one bit so a 1-pixel-wide or
    // 1-pixel-tall sprite still elaborates cleanly.
    localparam int SXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int SYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [SXW-1:0]   SX_LAST  = SXW'(SPR_W - 1);
    localparam logic [SYW-1:0]   SY_LAST  = SYW'(SPR_H - 1);
    localparam logic [CORDW:0]   FB_W_C   = (CORDW+1)'(FB_W);
    localparam logic [CORDW:0]   FB_H_C   = (CORDW+1)'(FB_H);
    localparam logic [WIDTH-1:0] TRANSP_C = WIDTH'(TRANSP);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t           state;
    logic [SXW-1:0]   sx;
    logic [SYW-1:0]   sy;
    logic [CORDW-1:0] xr;
    logic [CORDW-1:0] yr;

    // The pixel position carries one extra bit so a sprite hanging past the
    // top of the coordinate range clips instead of wrapping back on-screen.
    logic [CORDW:0] px;
    logic [CORDW:0] py;
    logic           visible;
    logic           opaque;

    // Sequencer: accepts a start in IDLE, walks every sprite pixel in DRAW
    // (advancing only when the framebuffer is ready), pulses done in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sx    <= '0;
            sy    <= '0;
            xr    <= '0;
            yr    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= x;
                        yr    <= y;
                        sx    <= '0;
                        sy    <= '0;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (fb_ready) begin
                        if (sx == SX_LAST) begin
                            sx <= '0;
                            if (sy == SY_LAST) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                sy <= sy + SYW'(1);
                            end
                        end else begin
                            sx <= sx + SXW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ROM address follows the walk counters while drawing and parks at zero
    // otherwise; the ROM answers in the same cycle.
    always_comb begin
        rom_addr = '0;
        if (state == DRAW) begin
            rom_addr = SPR_ADDRW'(sy) * SPR_ADDRW'(SPR_W) + SPR_ADDRW'(sx);
        end
    end

    // Screen position of the current pixel and whether it may be written.
    always_comb begin
        px      = {1'b0, xr} + (CORDW+1)'(sx);
        py      = {1'b0, yr} + (CORDW+1)'(sy);
        visible = (px < FB_W_C) && (py < FB_H_C);
        opaque  = (rom_data != TRANSP_C);
    end

    // Framebuffer write port: a write happens only for a visible, opaque
    // pixel in a cycle the framebuffer is accepting; the address is only
    // meaningful when the write is issued.
    always_comb begin
        fb_we   = (state == DRAW) && fb_ready && visible && opaque;
        fb_addr = FB_ADDRW'(py) * FB_ADDRW'(FB_W) + FB_ADDRW'(px);
        fb_data = rom_data;
    end

endmodule

// File: tb/tb_sprite_blit.sv
// tb_sprite_blit: drives sprite_blit with directed and randomized blits and
// compares every cycle against a pixel-walk reference model.
module tb_sprite_blit;

    localparam int WIDTH  = 4;
    localparam int SPR_W  = 4;
    localparam int SPR_H  = 4;
    localparam int FB_W   = 8;
    localparam int FB_H   = 6;
    localparam int CORDW  = 16;
    localparam int TRANSP = 0;
    localparam int NPIX   = SPR_W * SPR_H;
    localparam int SPR_ADDRW = $clog2(SPR_W*SPR_H);
    localparam int FB_ADDRW  = $clog2(FB_W*FB_H);

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [CORDW-1:0]     x;
    logic [CORDW-1:0]     y;
    logic                 busy;
    logic                 done;
    logic [SPR_ADDRW-1:0] rom_addr;
    logic [WIDTH-1:0]     rom_data;
    logic                 fb_ready;
    logic                 fb_we;
    logic [FB_ADDRW-1:0]  fb_addr;
    logic [WIDTH-1:0]     fb_data;

    logic [WIDTH-1:0] rom [NPIX];

    int nChecks = 0;
    int nPass   = 0;

    sprite_blit #(
        .WIDTH (WIDTH),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .FB_W  (FB_W),
        .FB_H  (FB_H),
        .CORDW (CORDW),
        .TRANSP(TRANSP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .fb_ready(fb_ready),
        .fb_we   (fb_we),
        .fb_addr (fb_addr),
        .fb_data (fb_data)
    );

    // Asynchronous sprite ROM
    assign rom_data = rom[rom_addr];

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed == expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // ROM used by the directed tests: values 1..15 with address 5 transparent.
    task automatic loadDirectedRom();
        for (int a = 0; a < NPIX; a++) begin
            if (a < 5)       rom[a] = WIDTH'(a + 1);
            else if (a == 5) rom[a] = '0;
            else             rom[a] = WIDTH'(a);
        end
    endtask

    // One blit from start to done, checked cycle by cycle.
    // stallMode: 0 = always ready, 1 = 3-cycle stall at pixel 7 then
    // alternate, 2 = random. resetAt > 0 asserts rst in that DRAW cycle.
    task automatic applyStimulus(input int bx, input int by, input int stallMode,
                                 input bit pulseDraw, input bit pulseDone,
                                 input int resetAt);
        int  k;
        int  cyc;
        int  stallIdx;
        int  nWrites;
        int  expWrites;
        int  sx, sy, px, py, d;
        bit  ready;
        bit  vis;
        bit  expWe;
        bit  finished;

        k = 0; cyc = 1; stallIdx = 0; nWrites = 0; expWrites = 0; finished = 0;

        @(posedge clk); #1;
        start    = 1'b1;
        x        = CORDW'(bx);
        y        = CORDW'(by);
        fb_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (cyc < 300 && !finished) begin
            ready = 1'b1;
            if (stallMode == 1 && k >= 7) begin
                ready = (stallIdx < 3) ? 1'b0 : (stallIdx % 2 == 1);
                stallIdx++;
            end else if (stallMode == 2) begin
                ready = ($urandom_range(0, 3) != 0);
            end

            start = 1'b0;
            if (k < NPIX) begin
                fb_ready = ready;
                if (pulseDraw && cyc == 3) begin
                    start = 1'b1;
                    x = CORDW'(bx + 1);
                    y = CORDW'(by + 1);
                end
            end else begin
                fb_ready = 1'($urandom_range(0, 1));
                if (pulseDone) begin
                    start = 1'b1;
                    x = CORDW'(bx + 2);
                    y = CORDW'(by + 2);
                end
            end
            if (resetAt > 0 && cyc == resetAt) rst = 1'b1;
            #4;

            if (k < NPIX) begin
                sx = k % SPR_W;
                sy = k / SPR_W;
                px = bx + sx;
                py = by + sy;
                d  = int'(rom[k]);
                vis   = (px < FB_W) && (py < FB_H);
                expWe = ready && vis && (d != TRANSP);
                if (expWe) expWrites++;
                if (fb_we) nWrites++;
                checkOutput("busy", int'(busy), 1);
                checkOutput("doneInDraw", int'(done), 0);
                checkOutput("romAddr", int'(rom_addr), k);
                checkOutput("fbWe", int'(fb_we), int'(expWe));
                if (expWe && fb_we) begin
                    checkOutput("fbAddr", int'(fb_addr), py * FB_W + px);
                    checkOutput("fbData", int'(fb_data), d);
                end
                if (ready) k++;
            end else begin
                checkOutput("done", int'(done), 1);
                checkOutput("busyInDone", int'(busy), 0);
                checkOutput("fbWeInDone", int'(fb_we), 0);
                finished = 1;
            end

            if (resetAt > 0 && cyc == resetAt) begin
                @(posedge clk); #1;
                rst   = 1'b0;
                start = 1'b0;
                #4;
                checkOutput("rstBusy", int'(busy), 0);
                checkOutput("rstFbWe", int'(fb_we), 0);
                checkOutput("rstDone", int'(done), 0);
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #5;
                    if (done || busy || fb_we) checkOutput("quietAfterRst", 1, 0);
                end
                return;
            end

            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        if (!finished) checkOutput("timeout", 0, 1);
        checkOutput("writeCount", nWrites, expWrites);

        if (pulseDone) begin
            @(posedge clk); #1;
            start = 1'b0;
            #4;
            checkOutput("idleAfterDone", int'(busy), 0);
            checkOutput("noSecondDone", int'(done), 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        x        = '0;
        y        = '0;
        fb_ready = 1'b1;
        loadDirectedRom();

        repeat (2) @(posedge clk);
        #5;
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetFbWe", int'(fb_we), 0);
        checkOutput("resetRomAddr", int'(rom_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] basic blit at (2,1)");
        applyStimulus(2, 1, 0, 0, 0, 0);
        $display("[TB] clipped blit at (6,4)");
        applyStimulus(6, 4, 0, 0, 0, 0);
        $display("[TB] off-screen blit at (200,0)");
        applyStimulus(200, 0, 0, 0, 0, 0);
        $display("[TB] stalled blit at (0,0)");
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        $display("[TB] starts during DRAW and DONE");
        applyStimulus(3, 2, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(5, 3, 0, 0, 0, 0);
        $display("[TB] reset mid-blit");
        applyStimulus(2, 1, 0, 0, 0, 5);
        applyStimulus(2, 1, 0, 0, 0, 0);

        $display("[TB] randomized blits");
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < NPIX; a++) begin
                rom[a] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, 15));
            end
            if (t == 9) applyStimulus(65530, 65534, 2, 0, 0, 0);
            else applyStimulus(int'($urandom_range(0, 11)), int'($urandom_range(0, 8)), 2, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
